// File: rtl/seg_display_pkg.sv
// Shared constants for the seven-segment scan driver: glyph codes, code width
// and the all-dark segment pattern.
package seg_display_pkg;

    localparam int unsigned CODE_W = 5;
    localparam int unsigned SEG_W  = 8;

    localparam logic [SEG_W-1:0] SEG_OFF = 8'hFF;

    localparam logic [CODE_W-1:0] GLYPH_N     = 5'h10;
    localparam logic [CODE_W-1:0] GLYPH_Q     = 5'h11;
    localparam logic [CODE_W-1:0] GLYPH_S     = 5'h12;
    localparam logic [CODE_W-1:0] GLYPH_P     = 5'h13;
    localparam logic [CODE_W-1:0] GLYPH_DASH  = 5'h14;
    localparam logic [CODE_W-1:0] GLYPH_BLANK = 5'h15;

endpackage

// File: rtl/seg_glyph_rom.sv
// Combinational glyph decoder: 5-bit code plus decimal point to active-low
// segments {dp, g..a}.
module seg_glyph_rom
    import seg_display_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    input  logic              dp,
    output logic [SEG_W-1:0]  glyphSeg_c
);

    logic [SEG_W-1:0] glyph;

    always_comb begin
        glyph = 8'hBF;
        case (code)
            5'h00:       glyph = 8'hC0;
            5'h01:       glyph = 8'hF9;
            5'h02:       glyph = 8'hA4;
            5'h03:       glyph = 8'hB0;
            5'h04:       glyph = 8'h99;
            5'h05:       glyph = 8'h92;
            5'h06:       glyph = 8'h82;
            5'h07:       glyph = 8'hF8;
            5'h08:       glyph = 8'h80;
            5'h09:       glyph = 8'h90;
            5'h0A:       glyph = 8'h88;
            5'h0B:       glyph = 8'h83;
            5'h0C:       glyph = 8'hC6;
            5'h0D:       glyph = 8'hA1;
            5'h0E:       glyph = 8'h86;
            5'h0F:       glyph = 8'h8E;
            GLYPH_N:     glyph = 8'hAB;
            GLYPH_Q:     glyph = 8'h98;
            GLYPH_S:     glyph = 8'h92;
            GLYPH_P:     glyph = 8'h8C;
            GLYPH_DASH:  glyph = 8'hBF;
            GLYPH_BLANK: glyph = SEG_OFF;
            default:     glyph = 8'hBF;
        endcase
        glyphSeg_c = dp ? (glyph & 8'h7F) : glyph;
    end

endmodule

// File: rtl/seg_display_scan.sv
// Time-multiplexed common-anode N-digit scanner with guard sub-tick, per-frame
// shadowed inputs, blanking, blinking and 16-level brightness.
module seg_display_scan
    import seg_display_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned TICK_DIV   = 1024
) (
    input  logic                         clk,
    input  logic                         rstN,
    input  logic                         en,
    input  logic [CODE_W*NUM_DIGITS-1:0] digitCodes,
    input  logic [NUM_DIGITS-1:0]        dpMask,
    input  logic [NUM_DIGITS-1:0]        blankMask,
    input  logic [NUM_DIGITS-1:0]        blinkMask,
    input  logic                         blinkTick,
    input  logic [3:0]                   brightness,
    output logic [NUM_DIGITS-1:0]        an,
    output logic [SEG_W-1:0]             segOut,
    output logic                         frameDone
);

    localparam int unsigned TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SLOT_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned CODES_W = CODE_W * NUM_DIGITS;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_DIGITS - 1);
    localparam logic [3:0]        SUB_LAST  = 4'hF;

    logic [TICK_W-1:0]     tickCnt;
    logic [3:0]            subTick;
    logic [SLOT_W-1:0]     slot;
    logic                  running;
    logic                  blinkPhase;

    logic [CODES_W-1:0]    shCodes;
    logic [NUM_DIGITS-1:0] shDp;
    logic [NUM_DIGITS-1:0] shBlank;
    logic [NUM_DIGITS-1:0] shBlink;
    logic [3:0]            shBright;
    logic                  shPhase;

    logic [TICK_W-1:0]     nTick;
    logic [3:0]            nSub;
    logic [SLOT_W-1:0]     nSlot;
    logic                  loadShadow;

    logic [CODES_W-1:0]    effCodes;
    logic [NUM_DIGITS-1:0] effDp;
    logic [NUM_DIGITS-1:0] effBlank;
    logic [NUM_DIGITS-1:0] effBlink;
    logic [3:0]            effBright;
    logic                  effPhase;
    logic [CODE_W-1:0]     curCode;
    logic                  curDp;
    logic                  curDark;
    logic                  onWindow;
    logic [SEG_W-1:0]      glyphSeg;

    // Next counter state; the first enabled cycle after idle is a frame start.
    always_comb begin
        nTick      = '0;
        nSub       = '0;
        nSlot      = '0;
        loadShadow = 1'b0;
        if (en && running) begin
            if (tickCnt == TICK_LAST) begin
                nSub = subTick + 4'd1;
                if (subTick == SUB_LAST) begin
                    nSlot = (slot == SLOT_LAST) ? '0 : slot + SLOT_W'(1);
                end else begin
                    nSlot = slot;
                end
            end else begin
                nTick = tickCnt + TICK_W'(1);
                nSub  = subTick;
                nSlot = slot;
            end
            loadShadow = (nTick == '0) && (nSub == '0) && (nSlot == '0);
        end else if (en) begin
            loadShadow = 1'b1;
        end
    end

    // On the frame-start edge the outputs see the values being captured.
    always_comb begin
        effCodes  = loadShadow ? digitCodes : shCodes;
        effDp     = loadShadow ? dpMask     : shDp;
        effBlank  = loadShadow ? blankMask  : shBlank;
        effBlink  = loadShadow ? blinkMask  : shBlink;
        effBright = loadShadow ? brightness : shBright;
        effPhase  = loadShadow ? (blinkPhase ^ blinkTick) : shPhase;
        curCode   = effCodes[int'(nSlot) * CODE_W +: CODE_W];
        curDp     = effDp[nSlot];
        curDark   = effBlank[nSlot] | (effBlink[nSlot] & effPhase);
        onWindow  = (nSub != 4'd0) && (nSub <= effBright) && !curDark;
    end

    seg_glyph_rom u_glyphRom (
        .code       (curCode),
        .dp         (curDp),
        .glyphSeg_c (glyphSeg)
    );

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            tickCnt    <= '0;
            subTick    <= '0;
            slot       <= '0;
            running    <= 1'b0;
            blinkPhase <= 1'b0;
            shCodes    <= '0;
            shDp       <= '0;
            shBlank    <= '0;
            shBlink    <= '0;
            shBright   <= '0;
            shPhase    <= 1'b0;
        end else begin
            tickCnt    <= nTick;
            subTick    <= nSub;
            slot       <= nSlot;
            running    <= en;
            blinkPhase <= blinkPhase ^ blinkTick;
            if (loadShadow) begin
                shCodes  <= digitCodes;
                shDp     <= dpMask;
                shBlank  <= blankMask;
                shBlink  <= blinkMask;
                shBright <= brightness;
                shPhase  <= blinkPhase ^ blinkTick;
            end
        end
    end

    // Segments are reloaded only on the guard sub-tick, while anodes are off.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            an        <= '1;
            segOut    <= SEG_OFF;
            frameDone <= 1'b0;
        end else if (!en) begin
            an        <= '1;
            segOut    <= SEG_OFF;
            frameDone <= 1'b0;
        end else begin
            an <= onWindow ? ~(NUM_DIGITS'(1) << nSlot) : '1;
            if (nSub == 4'd0) begin
                segOut <= curDark ? SEG_OFF : glyphSeg;
            end
            frameDone <= (nSlot == SLOT_LAST) && (nSub == SUB_LAST) && (nTick == TICK_LAST);
        end
    end

endmodule

// File: tb/tb_seg_display_scan.sv
// Bench for seg_display_scan (4 digits, 2 clocks per sub-tick): frame-position
// reference model checked every cycle, plus per-frame table and corner cases.
module tb_seg_display_scan;

    localparam int unsigned ND    = 4;
    localparam int unsigned TD    = 2;
    localparam int          FRAME = 128;
    localparam int          SLEN  = 32;

    logic        clk = 1'b0;
    logic        rstN;
    logic        en;
    logic [19:0] digitCodes;
    logic [3:0]  dpMask, blankMask, blinkMask, brightness;
    logic        blinkTick;
    logic [3:0]  an;
    logic [7:0]  segOut;
    logic        frameDone;

    int nChecks = 0;
    int nFails  = 0;

    seg_display_scan #(.NUM_DIGITS(ND), .TICK_DIV(TD)) dut (
        .clk        (clk),
        .rstN       (rstN),
        .en         (en),
        .digitCodes (digitCodes),
        .dpMask     (dpMask),
        .blankMask  (blankMask),
        .blinkMask  (blinkMask),
        .blinkTick  (blinkTick),
        .brightness (brightness),
        .an         (an),
        .segOut     (segOut),
        .frameDone  (frameDone)
    );

    always #5 clk = ~clk;

    logic [7:0] hexTab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    function automatic logic [7:0] refGlyph(input logic [4:0] c, input logic dp);
        logic [7:0] g;
        if (c < 5'h10) g = hexTab[c[3:0]];
        else begin
            case (c)
                5'h10:   g = 8'hAB;
                5'h11:   g = 8'h98;
                5'h12:   g = 8'h92;
                5'h13:   g = 8'h8C;
                5'h15:   g = 8'hFF;
                default: g = 8'hBF;
            endcase
        end
        if (dp) g[7] = 1'b0;
        return g;
    endfunction

    // Reference model: position within the frame plus a snapshot taken at frame start.
    int         mPos = 0;
    bit         mRun = 0;
    bit         mPhase = 0;
    bit         mShPhase = 0;
    logic [19:0] mCodes = '0;
    logic [3:0] mDp = '0, mBlank = '0, mBlink = '0, mBright = '0;
    logic [3:0] expAn = 4'hF;
    logic [7:0] expSeg = 8'hFF;
    logic       expFd = 1'b0;
    int         mSlot, mSub;
    bit         mCap, mDark;
    logic [4:0] mCode;

    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            mPos = 0; mRun = 0; mPhase = 0; mShPhase = 0;
            mCodes = '0; mDp = '0; mBlank = '0; mBlink = '0; mBright = '0;
            expAn = 4'hF; expSeg = 8'hFF; expFd = 1'b0;
        end else begin
            mPhase = mPhase ^ blinkTick;
            if (!en) begin
                mRun = 0; mPos = 0;
                expAn = 4'hF; expSeg = 8'hFF; expFd = 1'b0;
            end else begin
                if (!mRun) begin
                    mRun = 1; mPos = 0; mCap = 1;
                end else begin
                    mPos = (mPos + 1) % FRAME;
                    mCap = (mPos == 0);
                end
                if (mCap) begin
                    mCodes = digitCodes; mDp = dpMask; mBlank = blankMask;
                    mBlink = blinkMask; mBright = brightness; mShPhase = mPhase;
                end
                mSlot = mPos / SLEN;
                mSub  = (mPos % SLEN) / TD;
                mDark = mBlank[mSlot] || (mBlink[mSlot] && mShPhase);
                mCode = mCodes[mSlot*5 +: 5];
                expSeg = mDark ? 8'hFF : refGlyph(mCode, mDp[mSlot]);
                expAn  = 4'hF;
                if (mSub >= 1 && mSub <= int'(mBright) && !mDark) expAn[mSlot] = 1'b0;
                expFd = (mPos == FRAME - 1);
            end
        end
    end

    always @(negedge clk) begin
        nChecks++;
        if (an !== expAn || segOut !== expSeg || frameDone !== expFd) begin
            nFails++;
            $display("FAIL cycle-model t=%0t an=%h exp %h seg=%h exp %h fd=%b exp %b",
                     $time, an, expAn, segOut, expSeg, frameDone, expFd);
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    int         rOn [4];
    int         rFirst [4];
    logic [7:0] rSeg [4];
    int         rFdPos, rFdCnt, rBad;

    // Samples one aligned frame; optional code change and blink pulse mid-frame.
    task automatic runFrame(input int evAt, input logic [19:0] evCodes, input int pulseAt);
        for (int s = 0; s < 4; s++) begin
            rOn[s] = 0; rFirst[s] = -1; rSeg[s] = 8'h00;
        end
        rFdPos = -1; rFdCnt = 0; rBad = 0;
        for (int k = 0; k < FRAME; k++) begin
            int s;
            int off;
            logic [3:0] onPat;
            @(negedge clk);
            s = k / SLEN;
            off = k % SLEN;
            onPat = 4'hF;
            onPat[s] = 1'b0;
            if (an === onPat) begin
                rOn[s]++;
                if (rFirst[s] < 0) rFirst[s] = off;
            end else if (an !== 4'hF) rBad++;
            if (off == SLEN - 1) rSeg[s] = segOut;
            if (frameDone === 1'b1) begin rFdCnt++; rFdPos = k; end
            blinkTick = (k == pulseAt);
            if (k == evAt) digitCodes = evCodes;
        end
    endtask

    task automatic checkFrame(input string tag, input logic [3:0][7:0] eSeg, input logic [3:0][7:0] eOn);
        for (int s = 0; s < 4; s++) begin
            check($sformatf("%s seg%0d", tag, s), 32'(rSeg[s]), 32'(eSeg[s]));
            check($sformatf("%s onClocks%0d", tag, s), rOn[s], 32'(eOn[s]));
            if (eOn[s] != 0) check($sformatf("%s firstOn%0d", tag, s), rFirst[s], 2);
        end
        check({tag, " frameDoneCount"}, rFdCnt, 1);
        check({tag, " frameDonePos"}, rFdPos, FRAME - 1);
        check({tag, " strayAnode"}, rBad, 0);
    endtask

    task automatic waitFrameEnd(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frameDone !== 1'b1 && n < 400);
        check({tag, " frameEndTimeout"}, 32'(frameDone), 1);
    endtask

    typedef struct {
        logic [19:0]     codes;
        logic [3:0]      dp;
        logic [3:0]      blank;
        logic [3:0]      blink;
        logic [3:0]      bright;
        logic [3:0][7:0] seg;
        logic [3:0][7:0] on;
    } vec_t;

    vec_t vecs [7];

    initial begin
        vecs[0] = '{codes: {5'h03, 5'h02, 5'h01, 5'h00}, dp: 4'b0000, blank: 4'b0000, blink: 4'b0000,
                    bright: 4'd15, seg: {8'hB0, 8'hA4, 8'hF9, 8'hC0}, on: {8'd30, 8'd30, 8'd30, 8'd30}};
        vecs[1] = '{codes: {5'h13, 5'h12, 5'h11, 5'h10}, dp: 4'b0100, blank: 4'b0000, blink: 4'b0000,
                    bright: 4'd15, seg: {8'h8C, 8'h12, 8'h98, 8'hAB}, on: {8'd30, 8'd30, 8'd30, 8'd30}};
        vecs[2] = '{codes: {5'h1F, 5'h14, 5'h15, 5'h0A}, dp: 4'b0000, blank: 4'b0000, blink: 4'b0000,
                    bright: 4'd4, seg: {8'hBF, 8'hBF, 8'hFF, 8'h88}, on: {8'd8, 8'd8, 8'd8, 8'd8}};
        vecs[3] = '{codes: {5'h0F, 5'h0E, 5'h0D, 5'h0C}, dp: 4'b0000, blank: 4'b0000, blink: 4'b0000,
                    bright: 4'd0, seg: {8'h8E, 8'h86, 8'hA1, 8'hC6}, on: {8'd0, 8'd0, 8'd0, 8'd0}};
        vecs[4] = '{codes: {5'h07, 5'h06, 5'h05, 5'h04}, dp: 4'b1001, blank: 4'b0010, blink: 4'b0000,
                    bright: 4'd15, seg: {8'h78, 8'h82, 8'hFF, 8'h19}, on: {8'd30, 8'd30, 8'd0, 8'd30}};
        vecs[5] = '{codes: {5'h08, 5'h09, 5'h0B, 5'h0C}, dp: 4'b0000, blank: 4'b0000, blink: 4'b0000,
                    bright: 4'd1, seg: {8'h80, 8'h90, 8'h83, 8'hC6}, on: {8'd2, 8'd2, 8'd2, 8'd2}};
        vecs[6] = '{codes: {5'h01, 5'h01, 5'h01, 5'h01}, dp: 4'b0000, blank: 4'b0000, blink: 4'b0001,
                    bright: 4'd7, seg: {8'hF9, 8'hF9, 8'hF9, 8'hF9}, on: {8'd14, 8'd14, 8'd14, 8'd14}};

        rstN = 1'b0; en = 1'b1; blinkTick = 1'b0;
        digitCodes = {5'h03, 5'h02, 5'h01, 5'h00};
        dpMask = '0; blankMask = '0; blinkMask = '0; brightness = 4'd15;

        repeat (5) begin
            @(negedge clk);
            check("reset an", 32'(an), 32'h F);
            check("reset seg", 32'(segOut), 32'h FF);
            check("reset frameDone", 32'(frameDone), 0);
        end
        rstN = 1'b1;
        runFrame(-1, '0, -1);
        checkFrame("firstFrame", {8'hB0, 8'hA4, 8'hF9, 8'hC0}, {8'd30, 8'd30, 8'd30, 8'd30});

        for (int i = 0; i < 7; i++) begin
            digitCodes = vecs[i].codes; dpMask = vecs[i].dp; blankMask = vecs[i].blank;
            blinkMask = vecs[i].blink; brightness = vecs[i].bright;
            runFrame(-1, '0, -1);
            checkFrame($sformatf("vec%0d", i), vecs[i].seg, vecs[i].on);
        end

        // Mid-frame code change must not tear the current frame.
        digitCodes = {5'h03, 5'h02, 5'h01, 5'h00}; dpMask = '0; blankMask = '0;
        blinkMask = '0; brightness = 4'd15;
        runFrame(40, {5'h09, 5'h09, 5'h09, 5'h09}, -1);
        checkFrame("tearOld", {8'hB0, 8'hA4, 8'hF9, 8'hC0}, {8'd30, 8'd30, 8'd30, 8'd30});
        runFrame(-1, '0, -1);
        checkFrame("tearNew", {8'h90, 8'h90, 8'h90, 8'h90}, {8'd30, 8'd30, 8'd30, 8'd30});

        // Blink: mid-frame tick darkens digit 0 next frame; tick at frame start restores it.
        digitCodes = {5'h01, 5'h01, 5'h01, 5'h01}; blinkMask = 4'b0001;
        runFrame(-1, '0, 50);
        checkFrame("blinkVisible", {8'hF9, 8'hF9, 8'hF9, 8'hF9}, {8'd30, 8'd30, 8'd30, 8'd30});
        runFrame(-1, '0, -1);
        checkFrame("blinkDark", {8'hF9, 8'hF9, 8'hF9, 8'hFF}, {8'd30, 8'd30, 8'd30, 8'd0});
        blinkTick = 1'b1;
        runFrame(-1, '0, -1);
        checkFrame("blinkAtStart", {8'hF9, 8'hF9, 8'hF9, 8'hF9}, {8'd30, 8'd30, 8'd30, 8'd30});

        // Enable dropped mid-slot 2, then restored.
        digitCodes = {5'h04, 5'h03, 5'h02, 5'h01}; blinkMask = '0;
        repeat (70) @(negedge clk);
        en = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            check($sformatf("disabled an %0d", i), 32'(an), 32'h F);
            check($sformatf("disabled seg %0d", i), 32'(segOut), 32'h FF);
            check($sformatf("disabled frameDone %0d", i), 32'(frameDone), 0);
        end
        en = 1'b1;
        runFrame(-1, '0, -1);
        checkFrame("reEnable", {8'h99, 8'hB0, 8'hA4, 8'hF9}, {8'd30, 8'd30, 8'd30, 8'd30});

        // Randomized traffic; the reference model compares every cycle.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            blinkTick = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 15) == 0) digitCodes = 20'($urandom);
            if ($urandom_range(0, 63) == 0) dpMask = 4'($urandom);
            if ($urandom_range(0, 63) == 0) blankMask = 4'($urandom);
            if ($urandom_range(0, 63) == 0) blinkMask = 4'($urandom);
            if ($urandom_range(0, 31) == 0) brightness = 4'($urandom);
            if (en && $urandom_range(0, 499) == 0) en = 1'b0;
            else if (!en && $urandom_range(0, 9) == 0) en = 1'b1;
        end

        // Asynchronous reset in the middle of a lit slot.
        @(negedge clk);
        blinkTick = 1'b0; en = 1'b1; blankMask = '0; blinkMask = '0; brightness = 4'd15;
        waitFrameEnd("preReset");
        waitFrameEnd("preReset2");
        repeat (10) @(negedge clk);
        check("litBeforeReset an", 32'(an), 32'h E);
        #2 rstN = 1'b0;
        #1;
        check("asyncReset an", 32'(an), 32'h F);
        check("asyncReset seg", 32'(segOut), 32'h FF);
        check("asyncReset frameDone", 32'(frameDone), 0);
        @(negedge clk);
        rstN = 1'b1;
        repeat (20) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #1000000;
        nFails++;
        $display("FAIL watchdog: simulation did not finish by %0t", $time);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/seg_display_scan.md
# seg_display_scan

Parametrised, time-multiplexed driver for a common-anode N-digit seven-segment display with per-digit decimal point, blanking, blinking and 16-level brightness. It is the next-generation replacement for the fixed 4-digit scanner and sits between the vending-machine datapath (price, credit and coin glyphs) and the board's `an`/`segOut` pins. It generates its own scan rate from the system clock, adds an anti-ghosting guard, and latches inputs once per frame so that displayed digits never tear.

## Interface
- `NUM_DIGITS`, 4: digits scanned, 1..8.
- `TICK_DIV`, 1024: clocks per sub-tick, ≥1. One slot is 16 sub-ticks; one frame is `NUM_DIGITS` slots.
- `clk` input 1: system clock.
- `rstN` input 1: asynchronous, active-low reset.
- `en` input 1: scan enable.
- `digitCodes` input 5·NUM_DIGITS: glyph code per digit; digit i is at bits [5i+4:5i].
- `dpMask` input NUM_DIGITS: decimal point on for digit i.
- `blankMask` input NUM_DIGITS: digit i is dark.
- `blinkMask` input NUM_DIGITS: digit i is dark while the blink phase is 1.
- `blinkTick` input 1: one-cycle pulse that toggles the blink phase.
- `brightness` input 4: on sub-ticks per slot, 0..15.
- `an` output NUM_DIGITS: active-low anodes; `an[0]` is the rightmost digit.
- `segOut` output 8: active-low segments; bit7 = dp, bits6..0 = g..a.
- `frameDone` output 1: one-cycle pulse at the end of each frame.

## Operation
- Glyph codes and their `segOut` values with dp off:
  - 0x00–0x0F: hex digits, e.g. 0 = 0xC0, 1 = 0xF9, A = 0x88, F = 0x8E.
  - 0x10 n = 0xAB, 0x11 q = 0x98, 0x12 S = 0x92, 0x13 P = 0x8C.
  - 0x14 '-' = 0xBF.
  - 0x15 blank = 0xFF.
  - All other codes display '-'.
  - A dp on the digit clears bit7.
- Counters:
  - `tickCnt` runs 0..TICK_DIV-1.
  - `subTick` runs 0..15 and advances when `tickCnt` wraps.
  - `slot` runs 0..NUM_DIGITS-1 and advances when `subTick` wraps from 15, wrapping to 0.
- Frame start is `slot`=0, `subTick`=0, `tickCnt`=0. At frame start, `digitCodes`, `dpMask`, `blankMask`, `blinkMask`, `brightness` and the blink phase are copied into shadow registers. Display uses the shadow registers only.
- Per slot s:
  - Sub-tick 0 is the guard: `an` is all ones, and `segOut` is loaded with the glyph for digit s.
  - Sub-ticks 1..`brightness`: `an[s]`=0, all other anode bits 1.
  - Sub-ticks above `brightness`: `an` is all ones.
  - Digit s stays dark (`an` all ones, `segOut` 0xFF) for the whole slot if `blankMask[s]` is set, or if `blinkMask[s]` is set and the blink phase is 1.
- Blink phase:
  - Reset value 0; toggles on every `blinkTick`.
  - A toggle coinciding with frame start is captured by that same frame's shadow copy.
- `en`=0: `an` all ones, `segOut`=0xFF, all counters held at 0, shadows keep their values. `frameDone`=0. When `en` rises, the next cycle is a frame start.
- `brightness`=0: display is fully dark, but the scan and `frameDone` continue.

## Timing
- Reset values: `an` all ones, `segOut`=0xFF, `frameDone`=0, counters 0, blink phase 0, shadows 0. Reset asserted mid-frame blanks the outputs immediately.
- All outputs are registered.
- `an` and `segOut` change on the clock edge at which the counters enter the new state.
- `segOut` changes only during guard sub-ticks or while `an` is all ones.
- An input change is displayed from the next frame start. Worst-case latency is 16·TICK_DIV·NUM_DIGITS + 1 clocks.
- `frameDone` is high during the final clock of slot NUM_DIGITS-1, sub-tick 15.
- Frame period is exactly 16·TICK_DIV·NUM_DIGITS clocks.

## Structure
- Shared package `seg_display_pkg` holds:
  - the glyph code constants (GLYPH_N, GLYPH_Q, GLYPH_S, GLYPH_P, GLYPH_DASH, GLYPH_BLANK);
  - SEG_OFF = 8'hFF;
  - code width CODE_W = 5.
- Sub-module `seg_glyph_rom`: combinational 5-bit code plus dp → 8-bit active-low segments. Instantiated once, indexed by the current slot's shadow code.
- Top level contains the counters, shadow registers, blink toggle and output registers.

## Test plan
All scenarios use NUM_DIGITS=4, TICK_DIV=2, so slot = 32 clocks and frame = 128 clocks.

- **Reset and first frame:** hold reset 5 clocks, release with `en`=1, codes {3,2,1,0}, `brightness`=15.
  - During reset: `an`=4'hF, `segOut`=0xFF.
  - Slot 0: `an`=4'hE for 30 clocks, `segOut`=0xC0.
  - Slot 3 shows 0xB0 with `an`=4'h7.
  - `frameDone` pulses at clock 128.
- **Tearing:** change `digitCodes` mid-frame.
  - The old value is shown until the next frame start, then the new value.
- **Custom glyphs and dp:** codes {0x13, 0x12, 0x11, 0x10} with `dpMask`=4'b0100.
  - Expect 0xAB, 0x98, 0x12 (S with dp), 0x8C.
  - An undefined code 0x1F shows 0xBF.
- **Brightness:** `brightness`=4 gives exactly 8 clocks of `an[s]`=0 per slot, starting 2 clocks into the slot. `brightness`=0 keeps `an`=4'hF for the whole frame while `frameDone` still pulses.
- **Blank and blink:**
  - `blankMask`=4'b0010: digit 1 is dark every frame.
  - `blinkMask`=4'b0001 with one `blinkTick`: digit 0 is dark from the next frame, visible again after a second `blinkTick`.
  - `blinkTick` on the frame-start clock takes effect in that frame.
- **Enable:** drop `en` mid-slot 2.
  - Next cycle: `an`=4'hF, `segOut`=0xFF.
  - On re-enable, the scan restarts at slot 0 guard.
